// File: rtl/otg_hpi_pkg.sv
// rtl/otg_hpi_pkg.sv - shared types, HPI register map and sizing helpers for the HPI bus controller
package otg_hpi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    RECOVER
  } hpi_state_t;

  localparam logic [1:0] HPI_DATA    = 2'd0;
  localparam logic [1:0] HPI_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDRESS = 2'd2;
  localparam logic [1:0] HPI_STATUS  = 2'd3;

  // A zero-length phase still occupies one cycle so the bus never glitches.
  function automatic int unsigned phase_cycles(input int unsigned n);
    return (n == 0) ? 1 : n;
  endfunction

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Counter holds N-1 at most, so 2**w >= N is enough.
  function automatic int unsigned cnt_width(input int unsigned max_cyc);
    int unsigned w;
    w = 1;
    while (((1 << w) < max_cyc) && (w < 31)) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/otg_hpi_bus_ctrl.sv
// rtl/otg_hpi_bus_ctrl.sv - single-word CY7C67200 HPI bus cycle generator with programmable phase timing
module otg_hpi_bus_ctrl
  import otg_hpi_pkg::*;
#(
  parameter int unsigned DW          = 16,
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned PULSE_CYC   = 4,
  parameter int unsigned HOLD_CYC    = 2,
  parameter int unsigned RECOVER_CYC = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [1:0]    req_addr,
  input  logic          req_read,
  input  logic          req_write,
  input  logic [DW-1:0] req_wdata,
  output logic          req_ready,
  output logic [DW-1:0] req_rdata,
  output logic          req_rdata_valid,
  output logic [1:0]    otg_addr,
  output logic          otg_cs_n,
  output logic          otg_rd_n,
  output logic          otg_wr_n,
  output logic [DW-1:0] otg_data_out,
  output logic          otg_data_oe,
  input  logic [DW-1:0] otg_data_in
);

  localparam int unsigned S_N = phase_cycles(SETUP_CYC);
  localparam int unsigned P_N = phase_cycles(PULSE_CYC);
  localparam int unsigned H_N = phase_cycles(HOLD_CYC);
  localparam int unsigned R_N = phase_cycles(RECOVER_CYC);
  localparam int unsigned CW  = cnt_width(max4(S_N, P_N, H_N, R_N));

  localparam logic [CW-1:0] S_LD = CW'(S_N - 1);
  localparam logic [CW-1:0] P_LD = CW'(P_N - 1);
  localparam logic [CW-1:0] H_LD = CW'(H_N - 1);
  localparam logic [CW-1:0] R_LD = CW'(R_N - 1);

  hpi_state_t    state;
  logic [CW-1:0] cnt;
  logic          is_write;
  logic          accept;
  logic          phase_done;

  assign req_ready  = (state == IDLE);
  assign accept     = (state == IDLE) && (req_read || req_write);
  assign phase_done = (cnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else begin
      case (state)
        IDLE:    if (accept) cnt <= S_LD;
        SETUP:   cnt <= phase_done ? P_LD : cnt - 1'b1;
        PULSE:   cnt <= phase_done ? H_LD : cnt - 1'b1;
        HOLD:    cnt <= phase_done ? R_LD : cnt - 1'b1;
        RECOVER: cnt <= phase_done ? '0   : cnt - 1'b1;
        default: cnt <= '0;
      endcase
    end
  end

  // Bus outputs are set on the edge entering each phase, so they change together with state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      is_write        <= 1'b0;
      otg_addr        <= 2'd0;
      otg_cs_n        <= 1'b1;
      otg_rd_n        <= 1'b1;
      otg_wr_n        <= 1'b1;
      otg_data_out    <= '0;
      otg_data_oe     <= 1'b0;
      req_rdata       <= '0;
      req_rdata_valid <= 1'b0;
    end else begin
      req_rdata_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state        <= SETUP;
            is_write     <= req_write;
            otg_addr     <= req_addr;
            otg_data_out <= req_wdata;
            otg_cs_n     <= 1'b0;
            otg_data_oe  <= req_write;
          end
        end
        SETUP: begin
          if (phase_done) begin
            state <= PULSE;
            if (is_write) otg_wr_n <= 1'b0;
            else          otg_rd_n <= 1'b0;
          end
        end
        PULSE: begin
          if (phase_done) begin
            state    <= HOLD;
            otg_rd_n <= 1'b1;
            otg_wr_n <= 1'b1;
            // Sampled on the edge that releases rd_n, while the device still drives the bus.
            if (!is_write) begin
              req_rdata       <= otg_data_in;
              req_rdata_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (phase_done) begin
            state       <= RECOVER;
            otg_cs_n    <= 1'b1;
            otg_data_oe <= 1'b0;
          end
        end
        RECOVER: begin
          if (phase_done) state <= IDLE;
        end
        default: begin
          state       <= IDLE;
          otg_cs_n    <= 1'b1;
          otg_rd_n    <= 1'b1;
          otg_wr_n    <= 1'b1;
          otg_data_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_otg_hpi_bus_ctrl.sv
// tb/tb_otg_hpi_bus_ctrl.sv - randomized self-checking bench for otg_hpi_bus_ctrl, default and minimum timing
module tb_otg_hpi_bus_ctrl;
  import otg_hpi_pkg::*;

  localparam int RAW_S[2] = '{2, 0};
  localparam int RAW_P[2] = '{4, 1};
  localparam int RAW_H[2] = '{2, 1};
  localparam int RAW_R[2] = '{3, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       reset_n;
  logic [1:0][1:0]  req_addr;
  logic [1:0]       req_read, req_write;
  logic [1:0][15:0] req_wdata;
  logic [1:0]       req_ready;
  logic [1:0][15:0] req_rdata;
  logic [1:0]       req_rdata_valid;
  logic [1:0][1:0]  otg_addr;
  logic [1:0]       otg_cs_n, otg_rd_n, otg_wr_n;
  logic [1:0][15:0] otg_data_out;
  logic [1:0]       otg_data_oe;
  logic [1:0][15:0] otg_data_in;

  otg_hpi_bus_ctrl #(.DW(16), .SETUP_CYC(2), .PULSE_CYC(4), .HOLD_CYC(2), .RECOVER_CYC(3)) u_dflt (
    .clk(clk), .reset_n(reset_n[0]), .req_addr(req_addr[0]), .req_read(req_read[0]),
    .req_write(req_write[0]), .req_wdata(req_wdata[0]), .req_ready(req_ready[0]),
    .req_rdata(req_rdata[0]), .req_rdata_valid(req_rdata_valid[0]), .otg_addr(otg_addr[0]),
    .otg_cs_n(otg_cs_n[0]), .otg_rd_n(otg_rd_n[0]), .otg_wr_n(otg_wr_n[0]),
    .otg_data_out(otg_data_out[0]), .otg_data_oe(otg_data_oe[0]), .otg_data_in(otg_data_in[0])
  );

  otg_hpi_bus_ctrl #(.DW(16), .SETUP_CYC(0), .PULSE_CYC(1), .HOLD_CYC(1), .RECOVER_CYC(1)) u_min (
    .clk(clk), .reset_n(reset_n[1]), .req_addr(req_addr[1]), .req_read(req_read[1]),
    .req_write(req_write[1]), .req_wdata(req_wdata[1]), .req_ready(req_ready[1]),
    .req_rdata(req_rdata[1]), .req_rdata_valid(req_rdata_valid[1]), .otg_addr(otg_addr[1]),
    .otg_cs_n(otg_cs_n[1]), .otg_rd_n(otg_rd_n[1]), .otg_wr_n(otg_wr_n[1]),
    .otg_data_out(otg_data_out[1]), .otg_data_oe(otg_data_oe[1]), .otg_data_in(otg_data_in[1])
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0][15:0] exp_rdata;

  function automatic int eff(input int n);
    return (n == 0) ? 1 : n;
  endfunction

  function automatic string tg(input string n, input int d, input int k);
    return $sformatf("%s_d%0d_k%0d", n, d, k);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input int d, input string tag);
    check({tag, "_ready"}, 32'(req_ready[d]), 1);
    check({tag, "_cs_n"}, 32'(otg_cs_n[d]), 1);
    check({tag, "_rd_n"}, 32'(otg_rd_n[d]), 1);
    check({tag, "_wr_n"}, 32'(otg_wr_n[d]), 1);
    check({tag, "_oe"}, 32'(otg_data_oe[d]), 0);
    check({tag, "_valid"}, 32'(req_rdata_valid[d]), 0);
    check({tag, "_rdata"}, 32'(req_rdata[d]), 32'(exp_rdata[d]));
  endtask

  // Present a request and wait (bounded) for the cycle in which it is taken.
  task automatic start(input int d, input bit rd, input bit wr, input logic [1:0] a, input logic [15:0] wd);
    req_read[d]  = rd;
    req_write[d] = wr;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    for (int i = 0; i < 64 && req_ready[d] !== 1'b1; i++) @(negedge clk);
    check(tg("accept_ready", d, 0), 32'(req_ready[d]), 1);
    @(posedge clk);
    #1;
  endtask

  // Walk the access cycle by cycle against the phase timeline; optionally queue the next request.
  task automatic follow(input int d, input bit rd, input bit wr, input logic [1:0] a,
                        input logic [15:0] wd, input logic [15:0] din,
                        input bit nrd, input bit nwr, input logic [1:0] na, input logic [15:0] nwd);
    int ts, tp, th, tot;
    bit rdo, cs_low, sl;
    ts  = eff(RAW_S[d]);
    tp  = eff(RAW_P[d]);
    th  = eff(RAW_H[d]);
    tot = ts + tp + th + eff(RAW_R[d]);
    rdo = rd && !wr;
    req_read[d]  = nrd;
    req_write[d] = nwr;
    req_addr[d]  = na;
    req_wdata[d] = nwd;
    for (int k = 0; k < tot; k++) begin
      @(negedge clk);
      cs_low = (k < ts + tp + th);
      sl     = (k >= ts) && (k < ts + tp);
      if (rdo && k == ts + tp) exp_rdata[d] = din;
      check(tg("ready", d, k), 32'(req_ready[d]), 0);
      check(tg("cs_n", d, k), 32'(otg_cs_n[d]), 32'(!cs_low));
      check(tg("rd_n", d, k), 32'(otg_rd_n[d]), 32'(!(sl && rdo)));
      check(tg("wr_n", d, k), 32'(otg_wr_n[d]), 32'(!(sl && wr)));
      check(tg("oe", d, k), 32'(otg_data_oe[d]), 32'(wr && cs_low));
      check(tg("valid", d, k), 32'(req_rdata_valid[d]), 32'(rdo && k == ts + tp));
      check(tg("rdata", d, k), 32'(req_rdata[d]), 32'(exp_rdata[d]));
      if (cs_low) check(tg("addr", d, k), 32'(otg_addr[d]), 32'(a));
      if (cs_low && wr) check(tg("wdata", d, k), 32'(otg_data_out[d]), 32'(wd));
      otg_data_in[d] = sl ? din : ~din;
    end
    @(negedge clk);
    check(tg("ready_after", d, tot), 32'(req_ready[d]), 1);
    check(tg("cs_n_after", d, tot), 32'(otg_cs_n[d]), 1);
    check(tg("valid_after", d, tot), 32'(req_rdata_valid[d]), 0);
  endtask

  task automatic access(input int d, input bit rd, input bit wr, input logic [1:0] a,
                        input logic [15:0] wd, input logic [15:0] din);
    start(d, rd, wr, a, wd);
    follow(d, rd, wr, a, wd, din, 1'b0, 1'b0, 2'd0, 16'h0);
  endtask

  initial begin
    logic [15:0] w, r;
    logic [1:0]  a;
    bit          rd, wr;

    reset_n     = 2'b00;
    req_addr    = '0;
    req_read    = '0;
    req_write   = '0;
    req_wdata   = '0;
    otg_data_in = '0;
    exp_rdata   = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_idle(d, $sformatf("rst_d%0d", d));
      check(tg("rst_addr", d, 0), 32'(otg_addr[d]), 0);
      check(tg("rst_dout", d, 0), 32'(otg_data_out[d]), 0);
    end
    reset_n = 2'b11;
    @(negedge clk);

    access(0, 1'b0, 1'b1, HPI_ADDRESS, 16'h1234, 16'h0);
    access(0, 1'b1, 1'b0, HPI_DATA, 16'h0, 16'hBEEF);

    // Back-to-back: the read is held during the write and must be taken in the first IDLE cycle.
    w = 16'($urandom);
    r = 16'($urandom);
    start(0, 1'b0, 1'b1, HPI_ADDRESS, w);
    follow(0, 1'b0, 1'b1, HPI_ADDRESS, w, 16'h0, 1'b1, 1'b0, HPI_MAILBOX, 16'h0);
    start(0, 1'b1, 1'b0, HPI_MAILBOX, 16'h0);
    follow(0, 1'b1, 1'b0, HPI_MAILBOX, 16'h0, r, 1'b0, 1'b0, 2'd0, 16'h0);

    access(0, 1'b1, 1'b1, HPI_STATUS, 16'h5A5A, 16'hC3C3);

    access(1, 1'b1, 1'b0, HPI_DATA, 16'h0, 16'hBEEF);
    access(1, 1'b0, 1'b1, HPI_MAILBOX, 16'hA55A, 16'h0);

    for (int i = 0; i < 12; i++) begin
      rd = 1'($urandom);
      wr = rd ? 1'($urandom) : 1'b1;
      a  = 2'($urandom);
      w  = 16'($urandom);
      r  = 16'($urandom);
      access(i % 2, rd, wr, a, w, r);
    end

    // Reset during the read strobe: everything must release without a clock edge.
    start(0, 1'b1, 1'b0, HPI_DATA, 16'h0);
    req_read[0] = 1'b0;
    repeat (eff(RAW_S[0]) + 2) @(negedge clk);
    check("mid_rd_n_low", 32'(otg_rd_n[0]), 0);
    #2;
    reset_n[0] = 1'b0;
    #1;
    exp_rdata[0] = 16'h0;
    check_idle(0, "async_rst");
    @(negedge clk);
    reset_n[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_idle(0, $sformatf("post_rst_k%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
